// File: rtl/fp_pkg.sv
// Shared float32 constants, FSM state and operand classification for the
// square / square-root datapaths.
package fp_pkg;

    localparam int          EXP_BIAS    = 127;
    localparam logic [7:0]  EXP_SPECIAL = 8'hFF;
    localparam int          MANT_W      = 23;
    localparam int          SIG_W       = 24;
    localparam int          PROD_W      = 48;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        NORM = 2'd2,
        FIN  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        NORMAL  = 2'd0,
        ZERO    = 2'd1,
        DENORM  = 2'd2,
        SPECIAL = 2'd3
    } fp_class_t;

    function automatic fp_class_t fp_classify(input logic [7:0]        exp_in,
                                              input logic [MANT_W-1:0] mant_in);
        fp_class_t cls;
        if (exp_in == EXP_SPECIAL)
            cls = SPECIAL;
        else if (exp_in == 8'h00)
            cls = (mant_in == '0) ? ZERO : DENORM;
        else
            cls = NORMAL;
        return cls;
    endfunction

endpackage

// File: rtl/seq_mult24.sv
// 24x24 shift-add multiplier: one multiplier bit per cycle, LSB first.
// o_last is high during the final accumulate; the product is complete the cycle after.
module seq_mult24
    import fp_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic [SIG_W-1:0]  i_a,
    input  logic [SIG_W-1:0]  i_b,
    output logic              o_last,
    output logic [PROD_W-1:0] o_product
);

    logic [SIG_W-1:0]  r_a;
    logic [SIG_W-1:0]  r_b;
    logic [PROD_W-1:0] r_acc;
    logic [4:0]        r_cnt;
    logic              r_run;
    logic [PROD_W-1:0] w_addend;

    assign w_addend  = r_b[r_cnt] ? ({{(PROD_W-SIG_W){1'b0}}, r_a} << r_cnt) : '0;
    assign o_last    = r_run && (r_cnt == 5'(SIG_W-1));
    assign o_product = r_acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a   <= '0;
            r_b   <= '0;
            r_acc <= '0;
            r_cnt <= '0;
            r_run <= 1'b0;
        end else if (i_start) begin
            r_a   <= i_a;
            r_b   <= i_b;
            r_acc <= '0;
            r_cnt <= '0;
            r_run <= 1'b1;
        end else if (r_run) begin
            r_acc <= r_acc + w_addend;
            if (o_last)
                r_run <= 1'b0;
            else
                r_cnt <= r_cnt + 5'd1;
        end
    end

endmodule

// File: rtl/fp_square_seq.sv
// Sequential float32 squarer. Define FP_SQUARE_ROUND_EN for round-to-nearest-even;
// otherwise the significand is truncated to match the square-root estimator.
//
// state | meaning
// IDLE  | waiting for start; classifies operand, specials skip to FIN
// MUL   | 24-cycle significand multiply in seq_mult24
// NORM  | normalize, round, range-check into the result staging registers
// FIN   | publish staged result with a one-cycle done pulse
module fp_square_seq
    import fp_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_sign,
    input  logic [7:0]        in_exponent,
    input  logic [MANT_W-1:0] in_mantissa,
    output logic              busy,
    output logic              done,
    output logic              out_sign,
    output logic [7:0]        out_exponent,
    output logic [MANT_W-1:0] out_mantissa,
    output logic              incorrect
);

    state_t            r_state;
    logic [7:0]        r_exp;
    logic              r_res_sign;
    logic [7:0]        r_res_exp;
    logic [MANT_W-1:0] r_res_mant;
    logic              r_res_inc;

    fp_class_t         w_in_class;
    logic              w_mul_start;
    logic              w_mul_last;
    logic [PROD_W-1:0] w_p;
    logic [9:0]        w_e;
    logic [9:0]        w_e_rnd;
    logic [MANT_W-1:0] w_frac;
    logic [MANT_W-1:0] w_frac_rnd;
    logic              w_underflow;
    logic              w_overflow;

    assign w_in_class  = fp_classify(in_exponent, in_mantissa);
    assign w_mul_start = (r_state == IDLE) && start && (w_in_class == NORMAL);

    seq_mult24 u_mult (
        .clk       (clk),
        .rst       (rst),
        .i_start   (w_mul_start),
        .i_a       ({1'b1, in_mantissa}),
        .i_b       ({1'b1, in_mantissa}),
        .o_last    (w_mul_last),
        .o_product (w_p)
    );

    // Two's-complement 10-bit exponent; normal inputs keep it within -125..382.
    assign w_e    = {1'b0, r_exp, 1'b0} - 10'(EXP_BIAS) + {9'd0, w_p[PROD_W-1]};
    assign w_frac = w_p[PROD_W-1] ? w_p[46:24] : w_p[45:23];

`ifdef FP_SQUARE_ROUND_EN
    logic        w_guard;
    logic        w_sticky;
    logic        w_round_up;
    logic [23:0] w_frac_sum;

    assign w_guard    = w_p[PROD_W-1] ? w_p[23] : w_p[22];
    assign w_sticky   = w_p[PROD_W-1] ? (|w_p[22:0]) : (|w_p[21:0]);
    assign w_round_up = w_guard & (w_sticky | w_frac[0]);
    assign w_frac_sum = {1'b0, w_frac} + {23'd0, w_round_up};
    // A carry out leaves the fraction at zero and bumps the exponent.
    assign w_frac_rnd = w_frac_sum[MANT_W-1:0];
    assign w_e_rnd    = w_e + {9'd0, w_frac_sum[23]};
`else
    logic w_unused_lsb;

    assign w_unused_lsb = ^w_p[22:0];
    assign w_frac_rnd   = w_frac;
    assign w_e_rnd      = w_e;
`endif

    assign w_underflow = w_e[9] || (w_e == 10'd0);
    assign w_overflow  = !w_e_rnd[9] && (w_e_rnd >= 10'd255);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_exp        <= '0;
            r_res_sign   <= 1'b0;
            r_res_exp    <= '0;
            r_res_mant   <= '0;
            r_res_inc    <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            out_sign     <= 1'b0;
            out_exponent <= '0;
            out_mantissa <= '0;
            incorrect    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    done <= 1'b0;
                    busy <= start;
                    if (start) begin
                        r_exp <= in_exponent;
                        case (w_in_class)
                            NORMAL: begin
                                r_state <= MUL;
                            end
                            ZERO: begin
                                r_res_sign <= 1'b0;
                                r_res_exp  <= '0;
                                r_res_mant <= '0;
                                r_res_inc  <= 1'b0;
                                r_state    <= FIN;
                            end
                            default: begin
                                r_res_sign <= in_sign;
                                r_res_exp  <= in_exponent;
                                r_res_mant <= in_mantissa;
                                r_res_inc  <= 1'b1;
                                r_state    <= FIN;
                            end
                        endcase
                    end
                end
                MUL: begin
                    if (w_mul_last)
                        r_state <= NORM;
                end
                NORM: begin
                    r_res_sign <= 1'b0;
                    if (w_underflow) begin
                        r_res_exp  <= '0;
                        r_res_mant <= '0;
                        r_res_inc  <= 1'b1;
                    end else if (w_overflow) begin
                        r_res_exp  <= EXP_SPECIAL;
                        r_res_mant <= '0;
                        r_res_inc  <= 1'b1;
                    end else begin
                        r_res_exp  <= w_e_rnd[7:0];
                        r_res_mant <= w_frac_rnd;
                        r_res_inc  <= 1'b0;
                    end
                    r_state <= FIN;
                end
                FIN: begin
                    out_sign     <= r_res_sign;
                    out_exponent <= r_res_exp;
                    out_mantissa <= r_res_mant;
                    incorrect    <= r_res_inc;
                    done         <= 1'b1;
                    r_state      <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_square_seq.sv
// Self-checking bench for fp_square_seq against an arithmetic float32 squaring model.
module tb_fp_square_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        in_sign;
    logic [7:0]  in_exponent;
    logic [22:0] in_mantissa;
    logic        busy;
    logic        done;
    logic        out_sign;
    logic [7:0]  out_exponent;
    logic [22:0] out_mantissa;
    logic        incorrect;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fp_square_seq dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .in_sign      (in_sign),
        .in_exponent  (in_exponent),
        .in_mantissa  (in_mantissa),
        .busy         (busy),
        .done         (done),
        .out_sign     (out_sign),
        .out_exponent (out_exponent),
        .out_mantissa (out_mantissa),
        .incorrect    (incorrect)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Returns {incorrect, result} using exact integer arithmetic on the significands.
    function automatic logic [32:0] ref_sq(input logic [31:0] x);
        int              bexp;
        int              e;
        int              sh;
        longint unsigned m;
        longint unsigned p;
        longint unsigned q;
        longint unsigned rem;
        longint unsigned half;
        logic [31:0]     y;
        logic            inc;
        bexp = int'(x[30:23]);
        if (bexp == 255) begin
            y = x; inc = 1'b1;
        end else if (bexp == 0) begin
            if (x[22:0] == 23'd0) begin
                y = 32'd0; inc = 1'b0;
            end else begin
                y = x; inc = 1'b1;
            end
        end else begin
            m  = 64'd8388608 + longint'(x[22:0]);
            p  = m * m;
            sh = (p >= 64'd140737488355328) ? 24 : 23;
            e  = 2 * bexp - 127 + (sh - 23);
            q    = p >> sh;
            rem  = p - (q << sh);
            half = 64'd1 << (sh - 1);
`ifdef FP_SQUARE_ROUND_EN
            if (e > 0 && (rem > half || (rem == half && q[0]))) begin
                q = q + 1;
                if (q == 64'd16777216) begin
                    q = 64'd8388608;
                    e = e + 1;
                end
            end
`else
            if (rem > half) q = q + 0;
`endif
            if (e <= 0) begin
                y = 32'd0; inc = 1'b1;
            end else if (e >= 255) begin
                y = 32'h7F800000; inc = 1'b1;
            end else begin
                y = {1'b0, 8'(e), q[22:0]}; inc = 1'b0;
            end
        end
        return {inc, y};
    endfunction

    // Caller is at a negedge; returns at the negedge where done is high (or the bound expired).
    task automatic do_op(input logic [31:0] x, input string tag, input int glitch_at);
        logic [32:0] r;
        int          lat_exp;
        int          n;
        r       = ref_sq(x);
        lat_exp = (x[30:23] != 8'h00 && x[30:23] != 8'hFF) ? 27 : 2;
        {in_sign, in_exponent, in_mantissa} = x;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        n = 1;
        chk({tag, "_busy_after_start"}, {31'd0, busy}, 32'd1);
        while (done !== 1'b1 && n < 60) begin
            if (n == glitch_at) begin
                {in_sign, in_exponent, in_mantissa} = 32'h3F800000;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        start = 1'b0;
        chk({tag, "_latency"}, n, lat_exp);
        chk({tag, "_result"}, {out_sign, out_exponent, out_mantissa}, r[31:0]);
        chk({tag, "_incorrect"}, {31'd0, incorrect}, {31'd0, r[32]});
        chk({tag, "_busy_with_done"}, {31'd0, busy}, 32'd1);
    endtask

    task automatic idle_check(input string tag);
        @(negedge clk);
        chk({tag, "_done_drop"}, {31'd0, done}, 32'd0);
        chk({tag, "_busy_drop"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        logic [31:0] dir_ops [10];
        logic [31:0] x;
        logic        saw_done;
        int          sel;

        rst = 1'b1;
        start = 1'b0;
        {in_sign, in_exponent, in_mantissa} = 32'd0;
        repeat (3) @(negedge clk);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_result", {out_sign, out_exponent, out_mantissa}, 32'd0);
        chk("reset_incorrect", {31'd0, incorrect}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        dir_ops = '{32'h40000000, 32'h3FC00000, 32'hC0400000, 32'h7F800000, 32'h80000000,
                    32'h00000001, 32'h7F000000, 32'h1F800000, 32'h3FC00001, 32'hFFC00001};
        foreach (dir_ops[i]) begin
            do_op(dir_ops[i], $sformatf("dir%0d", i), 0);
            idle_check($sformatf("dir%0d", i));
        end

        // Back-to-back: next start presented in the done cycle.
        do_op(32'h40000000, "b2b_a", 0);
        do_op(32'h7F800000, "b2b_b", 0);
        do_op(32'h3FC00000, "b2b_c", 0);
        idle_check("b2b");

        do_op(32'h40400000, "glitch", 5);
        idle_check("glitch");

        // Reset during MUL around iteration 10.
        {in_sign, in_exponent, in_mantissa} = 32'h40000000;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_done", {31'd0, done}, 32'd0);
        chk("midrst_result", {out_sign, out_exponent, out_mantissa}, 32'd0);
        chk("midrst_incorrect", {31'd0, incorrect}, 32'd0);
        saw_done = 1'b0;
        repeat (40) begin
            @(negedge clk);
            saw_done |= done;
        end
        chk("midrst_no_done", {31'd0, saw_done}, 32'd0);

        // Reset and start together: reset wins.
        {in_sign, in_exponent, in_mantissa} = 32'h40000000;
        rst = 1'b1;
        start = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        chk("rst_start_busy", {31'd0, busy}, 32'd0);
        saw_done = 1'b0;
        repeat (35) begin
            @(negedge clk);
            saw_done |= done;
        end
        chk("rst_start_no_done", {31'd0, saw_done}, 32'd0);

        for (int k = 0; k < 40; k++) begin
            x = $urandom;
            sel = $urandom_range(0, 9);
            case (sel)
                0: x[30:23] = 8'hFF;
                1: x[30:23] = 8'h00;
                2: x[30:0]  = 31'd0;
                3, 4: ;
                default: x[30:23] = 8'($urandom_range(40, 215));
            endcase
            do_op(x, $sformatf("rnd%0d", k), 0);
            if ($urandom_range(0, 1) == 0)
                idle_check($sformatf("rnd%0d", k));
        end
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
